// File: rtl/video_line_palette.sv
// Ping-pong line buffers plus a 256-entry RGB palette feeding the VGA timing stage.
// Indices are read in step with the pixel stream; colour emerges two clocks later.
module video_line_palette #(
  parameter int H_ACTIVE = 640
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        next_frame,
  input  logic        next_line,
  input  logic        next_pixel,
  input  logic        lb_wr_en,
  input  logic [9:0]  lb_wr_addr,
  input  logic [7:0]  lb_wr_data,
  input  logic        render_done,
  output logic        render_start,
  output logic [9:0]  render_line,
  input  logic        pal_wr_en,
  input  logic [7:0]  pal_wr_addr,
  input  logic [11:0] pal_wr_data,
  input  logic        underflow_clr,
  output logic        underflow,
  output logic [11:0] palette_rgb_data
);

  localparam int         LB_DEPTH = 2 * H_ACTIVE;
  localparam logic [9:0] H_END    = 10'(H_ACTIVE);

  logic [7:0]  lb_mem  [LB_DEPTH];
  logic [11:0] pal_mem [256];

  logic        disp_bank_q, disp_bank_d;
  logic        wr_done_q, wr_done_d;
  logic        line_valid_q, line_valid_d;
  logic        underflow_q, underflow_d;
  logic        render_start_q, render_start_d;
  logic [9:0]  render_line_q, render_line_d;
  logic [9:0]  rd_x_q, rd_x_d;
  logic [7:0]  idx_q, idx_d;
  logic [11:0] rgb_q, rgb_d;

  logic        wr_bank;
  logic        rd_in_line;
  logic        lb_wr_ok;
  logic        done_now;
  logic [10:0] rd_addr;
  logic [10:0] wr_addr;

  always_comb begin
    wr_bank    = ~disp_bank_q;
    rd_in_line = rd_x_q < H_END;
    lb_wr_ok   = lb_wr_en && (lb_wr_addr < H_END);
    done_now   = wr_done_q | render_done;
    // Clamp columns so the bank offset never points past the buffer.
    rd_addr = {1'b0, (rd_in_line ? rd_x_q : 10'd0)}
            + (disp_bank_q ? 11'(H_ACTIVE) : 11'd0);
    wr_addr = {1'b0, (lb_wr_ok ? lb_wr_addr : 10'd0)}
            + (wr_bank ? 11'(H_ACTIVE) : 11'd0);
  end

  always_comb begin
    disp_bank_d    = disp_bank_q;
    wr_done_d      = wr_done_q;
    line_valid_d   = line_valid_q;
    underflow_d    = underflow_q;
    render_start_d = next_line;
    render_line_d  = render_line_q;
    rd_x_d         = rd_x_q;

    if (render_done) begin
      wr_done_d = 1'b1;
    end
    if (underflow_clr) begin
      underflow_d = 1'b0;
    end

    if (next_line) begin
      disp_bank_d  = ~disp_bank_q;
      line_valid_d = done_now;
      wr_done_d    = 1'b0;
      rd_x_d       = 10'd0;
      if (!done_now) begin
        underflow_d = 1'b1;
      end
    end else if (next_pixel && rd_in_line) begin
      rd_x_d = rd_x_q + 10'd1;
    end

    if (next_frame) begin
      render_line_d = 10'd0;
    end else if (next_line) begin
      render_line_d = render_line_q + 10'd1;
    end

    idx_d = (rd_in_line && line_valid_q) ? lb_mem[rd_addr] : 8'd0;
    // Palette is read in the same edge it may be written: old colour wins.
    rgb_d = pal_mem[idx_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_bank_q    <= 1'b0;
      wr_done_q      <= 1'b0;
      line_valid_q   <= 1'b0;
      underflow_q    <= 1'b0;
      render_start_q <= 1'b0;
      render_line_q  <= 10'd0;
      rd_x_q         <= 10'd0;
      idx_q          <= 8'd0;
      rgb_q          <= 12'd0;
    end else begin
      disp_bank_q    <= disp_bank_d;
      wr_done_q      <= wr_done_d;
      line_valid_q   <= line_valid_d;
      underflow_q    <= underflow_d;
      render_start_q <= render_start_d;
      render_line_q  <= render_line_d;
      rd_x_q         <= rd_x_d;
      idx_q          <= idx_d;
      rgb_q          <= rgb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lb_wr_ok) begin
      lb_mem[wr_addr] <= lb_wr_data;
    end
    if (pal_wr_en) begin
      pal_mem[pal_wr_addr] <= pal_wr_data;
    end
  end

  assign render_start     = render_start_q;
  assign render_line      = render_line_q;
  assign underflow        = underflow_q;
  assign palette_rgb_data = rgb_q;

endmodule

// File: tb/tb_video_line_palette.sv
// Bench for video_line_palette: a cycle model pushes expected colours to a
// queue as stimulus is driven; they are popped and compared two clocks later.
module tb_video_line_palette;
  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 700;

  logic        clk = 1'b0;
  logic        rst;
  logic        next_frame, next_line, next_pixel;
  logic        lb_wr_en;
  logic [9:0]  lb_wr_addr;
  logic [7:0]  lb_wr_data;
  logic        render_done, render_start;
  logic [9:0]  render_line;
  logic        pal_wr_en;
  logic [7:0]  pal_wr_addr;
  logic [11:0] pal_wr_data;
  logic        underflow_clr, underflow;
  logic [11:0] palette_rgb_data;

  always #5 clk = ~clk;

  video_line_palette #(.H_ACTIVE(H_ACTIVE)) dut (
    .clk(clk), .rst(rst), .next_frame(next_frame), .next_line(next_line),
    .next_pixel(next_pixel), .lb_wr_en(lb_wr_en), .lb_wr_addr(lb_wr_addr),
    .lb_wr_data(lb_wr_data), .render_done(render_done), .render_start(render_start),
    .render_line(render_line), .pal_wr_en(pal_wr_en), .pal_wr_addr(pal_wr_addr),
    .pal_wr_data(pal_wr_data), .underflow_clr(underflow_clr), .underflow(underflow),
    .palette_rgb_data(palette_rgb_data)
  );

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];
  logic [11:0] pal_m [256];
  logic [7:0]  lb_m  [2][H_ACTIVE];
  logic        m_disp, m_valid, m_done;
  int          m_x;

  task automatic idle_inputs();
    next_frame = 0; next_line = 0; next_pixel = 1;
    lb_wr_en = 0; lb_wr_addr = '0; lb_wr_data = '0;
    render_done = 0; pal_wr_en = 0; pal_wr_addr = '0; pal_wr_data = '0;
    underflow_clr = 0;
  endtask

  // One clock: advance the model with the driven inputs, then score the output.
  task automatic step();
    logic [7:0]  idx;
    logic [11:0] e;
    if (pal_wr_en) pal_m[pal_wr_addr] = pal_wr_data;
    idx = (m_x < H_ACTIVE && m_valid) ? lb_m[m_disp][m_x] : 8'd0;
    exp_q.push_back(pal_m[idx]);
    if (lb_wr_en && lb_wr_addr < 10'(H_ACTIVE)) lb_m[~m_disp][lb_wr_addr] = lb_wr_data;
    if (render_done) m_done = 1'b1;
    if (next_line) begin
      m_valid = m_done;
      m_done  = 1'b0;
      m_disp  = ~m_disp;
      m_x     = 0;
    end else if (next_pixel && m_x < H_ACTIVE) begin
      m_x++;
    end
    @(posedge clk); #1;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      checks++;
      if (palette_rgb_data !== e) begin
        errors++;
        $display("FAIL pixel_rgb t=%0t got %h expected %h", $time, palette_rgb_data, e);
      end
    end
  endtask

  task automatic run_line(input int done_x, input logic fill, input logic [7:0] fill_idx,
                          input int pal_x, input logic [7:0] pal_a, input logic [11:0] pal_d,
                          input int clr_x, input int bad_x, input logic frame);
    for (int x = 0; x < H_TOTAL; x++) begin
      next_line     = (x == H_TOTAL - 1);
      next_frame    = frame && (x == H_TOTAL - 1);
      render_done   = (x == done_x);
      underflow_clr = (x == clr_x);
      lb_wr_en      = fill && (x < H_ACTIVE);
      lb_wr_addr    = 10'(x);
      lb_wr_data    = fill_idx;
      if (x == bad_x) begin
        lb_wr_en = 1; lb_wr_addr = 10'd700; lb_wr_data = 8'hAA;
      end
      pal_wr_en   = (x == pal_x);
      pal_wr_addr = pal_a;
      pal_wr_data = pal_d;
      step();
    end
    idle_inputs();
  endtask

  task automatic check_status(input string name, input logic exp_uf, input logic [9:0] exp_rl);
    checks++;
    if (underflow !== exp_uf) begin
      errors++; $display("FAIL %s underflow got %b expected %b", name, underflow, exp_uf);
    end
    checks++;
    if (render_line !== exp_rl) begin
      errors++; $display("FAIL %s render_line got %0d expected %0d", name, render_line, exp_rl);
    end
    checks++;
    if (render_start !== 1'b1) begin
      errors++; $display("FAIL %s render_start got %b expected 1", name, render_start);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    exp_q.delete();
    m_disp = 0; m_valid = 0; m_done = 0; m_x = 0;
    checks++;
    if (palette_rgb_data !== 12'h000 || render_start !== 1'b0 || render_line !== 10'd0
        || underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rgb=%h rs=%b rl=%0d uf=%b expected 000/0/0/0",
               palette_rgb_data, render_start, render_line, underflow);
    end
    // Program the palette while the read column is parked at 0.
    next_pixel = 0;
    for (int i = 0; i < 5; i++) begin
      pal_wr_en = 1;
      case (i)
        0: begin pal_wr_addr = 8'd0;   pal_wr_data = 12'h123; end
        1: begin pal_wr_addr = 8'd5;   pal_wr_data = 12'hF0A; end
        2: begin pal_wr_addr = 8'd7;   pal_wr_data = 12'h777; end
        3: begin pal_wr_addr = 8'd9;   pal_wr_data = 12'h0C3; end
        default: begin pal_wr_addr = 8'hAA; pal_wr_data = 12'h0AA; end
      endcase
      step();
    end
    idle_inputs();
  endtask

  task automatic test_startup_underflow();
    run_line(-1, 0, 8'd0, -1, 8'd0, 12'h0, -1, -1, 0);
    check_status("first_line", 1'b1, 10'd1);
    run_line(-1, 0, 8'd0, -1, 8'd0, 12'h0, -1, -1, 0);
    check_status("second_line", 1'b1, 10'd2);
  endtask

  task automatic test_render_fill();
    run_line(650, 1, 8'd5, -1, 8'd0, 12'h0, 10, -1, 0);
    check_status("fill5_clr", 1'b0, 10'd3);
  endtask

  task automatic test_done_on_next_line();
    run_line(H_TOTAL - 1, 1, 8'd7, -1, 8'd0, 12'h0, -1, -1, 0);
    check_status("done_same_cycle", 1'b0, 10'd4);
  endtask

  task automatic test_collision_and_bad_addr();
    run_line(645, 1, 8'd9, 100, 8'd7, 12'hE1E, -1, 660, 0);
    check_status("collision", 1'b0, 10'd5);
  endtask

  task automatic test_clr_vs_underflow();
    run_line(-1, 0, 8'd0, -1, 8'd0, 12'h0, H_TOTAL - 1, -1, 0);
    check_status("clr_coincident", 1'b1, 10'd6);
  endtask

  task automatic test_frame();
    run_line(-1, 0, 8'd0, -1, 8'd0, 12'h0, -1, -1, 1);
    check_status("frame", 1'b1, 10'd0);
    for (int n = 1; n <= 2; n++) begin
      step();
      checks++;
      if (render_start !== 1'b0) begin
        errors++; $display("FAIL render_start_pulse got %b expected 0", render_start);
      end
      run_line(-1, 0, 8'd0, -1, 8'd0, 12'h0, -1, -1, 0);
      check_status("frame_next", 1'b1, 10'(n));
    end
  endtask

  initial begin
    test_reset();
    test_startup_underflow();
    test_render_fill();
    test_done_on_next_line();
    test_collision_and_bad_addr();
    test_clr_vs_underflow();
    test_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
